// File: rtl/serial_and_reducer.sv
// rtl/serial_and_reducer.sv - serial AND reduction of fixed-length bit frames
// Bits arrive one per accept; frame results are held on a valid/ready port until taken.
module serial_and_reducer #(
   parameter int N_BITS = 3,
   parameter int CNT_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_partial,
   output logic             out_final,
   output logic [CNT_W-1:0] out_first_zero
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BITS - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] zidx;
   logic             acc;
   logic             zero_seen;
   logic             accept;

   assign accept = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   // Handshake outputs depend only on the state register.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && (cnt == LAST)) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = ACCUM;
            end
         end
         default: state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt            <= '0;
         acc            <= 1'b1;
         zero_seen      <= 1'b0;
         zidx           <= '0;
         out_partial    <= 1'b0;
         out_final      <= 1'b0;
         out_first_zero <= '0;
      end else if (accept) begin
         acc <= acc & in_bit;
         if (!in_bit && !zero_seen) begin
            zidx      <= cnt;
            zero_seen <= 1'b1;
         end
         if (cnt == ONE) begin
            out_partial <= acc & in_bit;
         end
         if (cnt == LAST) begin
            out_final      <= acc & in_bit;
            out_first_zero <= zero_seen ? zidx : (in_bit ? LAST : cnt);
            cnt            <= '0;
         end else begin
            cnt <= cnt + ONE;
         end
      end else if ((state == HOLD) && out_ready) begin
         // Result registers are left alone so they stay readable until overwritten.
         acc       <= 1'b1;
         zero_seen <= 1'b0;
         zidx      <= '0;
      end
   end

endmodule

// File: tb/tb_serial_and_reducer.sv
// tb/tb_serial_and_reducer.sv - scoreboard bench for serial_and_reducer
module tb_serial_and_reducer;

   localparam int N_BITS = 3;
   localparam int CNT_W  = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_bit = 1'b0;
   logic             out_ready = 1'b0;
   logic             in_ready;
   logic             out_valid;
   logic             out_partial;
   logic             out_final;
   logic [CNT_W-1:0] out_first_zero;

   typedef struct {
      int p;
      int f;
      int z;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   serial_and_reducer #(.N_BITS(N_BITS), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_bit        (in_bit),
      .in_ready      (in_ready),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_partial   (out_partial),
      .out_final     (out_final),
      .out_first_zero(out_first_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Results are compared when the handshake is about to complete on the next edge.
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("partial", int'(out_partial), e.p);
            chk("final", int'(out_final), e.f);
            chk("first_zero", int'(out_first_zero), e.z);
         end
      end
   end

   task automatic send_bit(input logic b);
      int n = 0;
      in_valid = 1'b1;
      in_bit   = b;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", int'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   function automatic exp_t model(input logic [N_BITS-1:0] b);
      exp_t e;
      e.p = int'(b[0] & b[1]);
      e.f = int'(&b);
      e.z = N_BITS - 1;
      for (int i = N_BITS - 1; i >= 0; i--) begin
         if (!b[i]) e.z = i;
      end
      return e;
   endfunction

   task automatic send_frame(input logic [N_BITS-1:0] b);
      sb.push_back(model(b));
      for (int i = 0; i < N_BITS; i++) send_bit(b[i]);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_partial", int'(out_partial), 0);
      chk("rst_final", int'(out_final), 0);
      chk("rst_first_zero", int'(out_first_zero), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      out_ready = 1'b1;
      send_frame(3'b111);
      #1;
      chk("valid_after_last", int'(out_valid), 1);
      chk("ready_low_in_hold", int'(in_ready), 0);
      @(negedge clk);
      #1;
      chk("valid_one_cycle", int'(out_valid), 0);
      chk("ready_after_hold", int'(in_ready), 1);

      send_frame(3'b101);  // stream 1,0,1
      send_frame(3'b011);  // stream 1,1,0
      send_frame(3'b100);  // stream 0,0,1
      @(negedge clk);

      out_ready = 1'b0;
      send_frame(3'b111);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_bit   = 1'b0;
         #1;
         chk("bp_in_ready", int'(in_ready), 0);
         chk("bp_out_valid", int'(out_valid), 1);
         chk("bp_partial", int'(out_partial), 1);
         chk("bp_final", int'(out_final), 1);
         chk("bp_first_zero", int'(out_first_zero), 2);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      chk("bp_released", int'(out_valid), 0);
      out_ready = 1'b1;
      send_frame(3'b111);
      @(negedge clk);

      send_bit(1'b0);
      send_bit(1'b0);
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("mid_rst_valid", int'(out_valid), 0);
         chk("mid_rst_partial", int'(out_partial), 0);
         chk("mid_rst_final", int'(out_final), 0);
         chk("mid_rst_first_zero", int'(out_first_zero), 0);
         @(negedge clk);
      end
      rst_n = 1'b1;
      sb.push_back(model(3'b111));
      send_bit(1'b1);
      @(negedge clk);
      send_bit(1'b1);
      repeat (2) @(negedge clk);
      send_bit(1'b1);

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_and_reducer.md
# serial_and_reducer

Sequential counterpart to the team's combinational staged-AND gate. This block receives operand bits one per cycle over a valid/ready stream and reduces each fixed-length frame to two results. The partial result is the AND of the first two bits. The final result is the AND of all bits. Results are presented on a valid/ready output port and held until the consumer accepts them. It sits between a serial bit source and any logic that previously consumed a parallel staged-AND result.

## Interface
- N_BITS, default 3: frame length in bits; legal range 2..2**CNT_W.
- CNT_W, default 4: width of the bit counter and of out_first_zero.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low, synchronous release to clk.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  operand bit.
- in_ready  output  1  block can accept a bit this cycle.
- out_valid  output  1  frame result available.
- out_ready  input  1  consumer accepts the result this cycle.
- out_partial  output  1  AND of frame bits 0 and 1.
- out_final  output  1  AND of all N_BITS frame bits.
- out_first_zero  output  CNT_W  index of the first 0 bit in the frame; N_BITS-1 when out_final=1 (don't-care by contract, fixed for verification).

## Operation
- The FSM has two states.
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Both in_ready and out_valid decode directly from the state register. No combinational path runs from inputs to outputs.
- A bit is accepted when in_valid & in_ready. Only accepted bits change state.
- Internal registers:
  - acc, set to 1 at frame start.
  - cnt, counts 0..N_BITS-1.
  - zero_seen.
  - zidx.
- On each accept in ACCUM:
  - acc <= acc & in_bit.
  - If in_bit=0 and zero_seen=0: zidx <= cnt and zero_seen <= 1.
  - If cnt==1: out_partial <= acc & in_bit.
  - If cnt==N_BITS-1:
    - out_final <= acc & in_bit.
    - out_first_zero <= (zero_seen ? zidx : (in_bit ? N_BITS-1 : cnt)).
    - State goes to HOLD.
    - cnt <= 0.
  - Otherwise cnt <= cnt+1.
- In HOLD, when out_ready=1:
  - State returns to ACCUM.
  - acc <= 1, zero_seen <= 0, zidx <= 0.
  - out_partial, out_final and out_first_zero keep their values until the next frame overwrites them.
- In HOLD, in_valid is ignored. No bit is consumed and there is no bypass or skid buffer.
- When N_BITS=2, out_partial equals out_final.
- Reset values (async, rst_n=0):
  - State ACCUM, so in_ready=1 and out_valid=0.
  - out_partial=0, out_final=0, out_first_zero=0.
  - cnt=0, acc=1, zero_seen=0, zidx=0.
- Reset mid-frame discards all accepted bits. The next accepted bit is bit 0 of a new frame.

## Timing
- Latency: out_valid rises on the clock edge that accepts bit N_BITS-1. It is visible in the following cycle.
- Throughput: at most one frame per N_BITS+1 cycles, with one bubble cycle for the HOLD handshake.
- out_valid stays high, and all out_* stay stable, until the cycle in which out_ready=1. out_valid falls on that clock edge.
- When out_ready=1 in HOLD, in_ready=1 in the next cycle. A bit presented in that cycle is accepted as bit 0.
- out_ready has no effect in ACCUM.
- Gaps in in_valid stall accumulation without altering any state.

## Test plan
- Reset release with N_BITS=3, then stream 1,1,1 back-to-back with out_ready=1:
  - out_valid=1 for exactly one cycle, starting the cycle after the third accept.
  - out_partial=1, out_final=1, out_first_zero=2.
- Stream 1,0,1:
  - out_partial=0, out_final=0, out_first_zero=1.
- Stream 1,1,0:
  - out_partial=1, out_final=0, out_first_zero=2.
- Stream 0,0,1:
  - out_partial=0, out_final=0, out_first_zero=0.
- Backpressure:
  - After frame 1,1,1, hold out_ready=0 for 5 cycles while driving in_valid=1 with in_bit=0.
  - Required: in_ready=0, out_valid=1 and outputs unchanged for all 5 cycles.
  - Then assert out_ready=1 for one cycle, then send 1,1,1. The new frame result must be partial=1, final=1, showing that no bits were consumed during HOLD.
- Reset mid-frame and stall:
  - Accept 0,0, assert rst_n=0 for 2 cycles, release.
  - Send 1, an idle cycle, 1, two idle cycles, 1.
  - Required: out_final=1 and out_first_zero=2.
  - Also required: out_partial=0, out_final=0, out_first_zero=0 and out_valid=0 while rst_n=0.
